fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single FIFO write port (write_enb, data_in, full) among NUM_REQ producers. Each producer uses a valid/ready handshake. A grant is held for a burst of up to BURST_MAX writes, then rotates to the next requester. The block sits between the producer agents/RTL sources and the FIFO write side, and guarantees no write is issued while the FIFO reports full.

---
 rtl/fifo_wr_arbiter_if.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Bundle of signals between the producers, the arbiter and the
//               FIFO write port.
//               master - producer/FIFO side: drives req_valid, req_data, full;
//                        observes req_ready, write_enb, data_in, grant_vld,
//                        grant_id, wr_count
//               slave  - arbiter side: the mirror image of master
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      full;
  logic                      write_enb;
  logic [DATA_W-1:0]         data_in;
  logic                      grant_vld;
  logic [ID_W-1:0]           grant_id;
  logic [15:0]               wr_count;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, write_enb, data_in, grant_vld, grant_id, wr_count
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, write_enb, data_in, grant_vld, grant_id, wr_count
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//               valid/ready producers. A grant lasts for up to BURST_MAX
//               writes, or until the granted producer drops valid, and then
//               rotates. No write is issued while the FIFO reports full.
// Ports       : clk   - clock, all state updates on the rising edge
//               reset - asynchronous, active-high reset
//               bus   - slave modport of fifo_wr_arbiter_if
//                       (req_valid/req_data/full in;
//                        req_ready/write_enb/data_in/grant_vld/grant_id/
//                        wr_count out)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input wire               clk,
  input wire               reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  // Holds 0..BURST_MAX so the final increment before release cannot wrap.
  localparam int BC_W = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_q,     state_d;
  logic [ID_W-1:0]   grant_id_q,  grant_id_d;
  logic [ID_W-1:0]   last_ptr_q,  last_ptr_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [15:0]       wr_count_q,  wr_count_d;

  logic [DATA_W-1:0] w_data [NUM_REQ];
  logic              w_granted;
  logic              w_cur_valid;
  logic              w_xfer;
  logic              w_sel_found;
  logic [ID_W-1:0]   w_sel_id;
  logic [ID_W-1:0]   w_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_data[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  // Outputs are gated by reset as well as by the state so that nothing can
  // reach the FIFO while reset is high, independent of register timing.
  assign w_granted   = (state_q == ST_GRANT) && !reset;
  assign w_cur_valid = bus.req_valid[grant_id_q];
  assign w_xfer      = w_granted && w_cur_valid && !bus.full;

  assign bus.write_enb = w_xfer;
  assign bus.data_in   = w_granted ? w_data[grant_id_q] : '0;
  assign bus.grant_vld = w_granted;
  assign bus.grant_id  = grant_id_q;
  assign bus.wr_count  = wr_count_q;

  always_comb begin
    bus.req_ready = '0;
    if (w_xfer) begin
      bus.req_ready[grant_id_q] = 1'b1;
    end
  end

  // Round-robin search: first valid requester starting just after the
  // previous winner, wrapping around.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = '0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(last_ptr_q) + k) % NUM_REQ);
      if (!w_sel_found && bus.req_valid[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wr_count_d  = wr_count_q;
    case (state_q)
      ST_IDLE: begin
        if (w_sel_found) begin
          state_d     = ST_GRANT;
          grant_id_d  = w_sel_id;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!w_cur_valid) begin
          // Producer gave up mid-burst: release without writing.
          state_d    = ST_IDLE;
          last_ptr_d = grant_id_q;
        end else if (!bus.full) begin
          if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
          end
          burst_cnt_d = burst_cnt_q + BC_W'(1);
          if (burst_cnt_q == BC_W'(BURST_MAX - 1)) begin
            state_d    = ST_IDLE;
            last_ptr_d = grant_id_q;
          end
        end
        // full with valid held: stall, grant and burst count unchanged.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      last_ptr_q  <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_count_q  <= wr_count_d;
    end
  end

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.req_ready));
  a_no_write_full : assert property (@(posedge clk) disable iff (reset)
    bus.write_enb |-> !bus.full);
  a_we_is_ready   : assert property (@(posedge clk) disable iff (reset)
    bus.write_enb == (|bus.req_ready));

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter. Producer queues feed
//               the requesters; expected writes are queued when stimulus is
//               issued and a monitor pops/compares on every FIFO write.
//               A second instance (BURST_MAX=15) runs the wr_count
//               saturation scenario in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 4;
  localparam int ID_W      = 2;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fifo_wr_arbiter_if #(.NUM_REQ(2), .DATA_W(8), .ID_W(1)) bus2 ();
  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_W(8), .BURST_MAX(15)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } exp_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q [$];
  logic [DATA_W-1:0] pq [NUM_REQ][$];
  logic [NUM_REQ-1:0] acc;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- producers ----------------
  always @(negedge clk) acc = bus.req_ready & bus.req_valid;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && pq[i].size() != 0) void'(pq[i].pop_front());
      if (pq[i].size() != 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_data[i*DATA_W +: DATA_W] = pq[i][0];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.write_enb === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {22'h0, bus.grant_id, bus.data_in}, 32'hDEAD_0000);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_write", {bus.req_ready, bus.grant_id, bus.data_in},
              {4'b0001 << mon_e.id, mon_e.id, mon_e.data});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input int r, input logic [7:0] d);
    pq[r].push_back(d);
  endtask

  task automatic expect_wr(input int r, input logic [7:0] d);
    exp_t t;
    t.id   = ID_W'(r);
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic chk_idle(input string name);
    check(name, {bus.write_enb, bus.req_ready, bus.data_in, bus.grant_vld,
                 bus.grant_id, bus.wr_count}, 32'h0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    exp_q.delete();
    repeat (2) step();
    chk_idle("reset_state");
    reset = 1'b0;
  endtask

  task automatic wait_wr(input logic [15:0] n);
    for (int k = 0; k < 200 && bus.wr_count != n; k++) step();
    check("wait_wr_count", {16'h0, bus.wr_count}, {16'h0, n});
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) step();
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed tests on dut ----------------
  task automatic run_main();
    logic [8:0] pat;

    // T1: single requester, burst split 4 + 2 with one bubble.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      feed(0, 8'hA0 + 8'(k));
      expect_wr(0, 8'hA0 + 8'(k));
    end
    @(posedge clk);
    #2;
    pat = 9'b011011110;   // bit c = write_enb in cycle c
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("t1_we_pattern", {31'h0, bus.write_enb}, {31'h0, pat[c]});
    end
    step();
    check("t1_wr_count", {16'h0, bus.wr_count}, 32'd6);
    check("t1_released", {31'h0, bus.grant_vld}, 32'd0);
    drain();

    // T2: all four valid, order 0,1,2,3,0 with 4 writes each.
    do_reset();
    for (int k = 0; k < 8; k++) feed(0, 8'h00 + 8'(k));
    for (int r = 1; r < 4; r++)
      for (int k = 0; k < 4; k++) feed(r, 8'(r * 16 + k));
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) expect_wr(r, 8'(r * 16 + k));
    for (int k = 4; k < 8; k++) expect_wr(0, 8'(k));
    drain();
    step();
    check("t2_wr_count", {16'h0, bus.wr_count}, 32'd20);

    // T3: requester 2 stalled by full for 5 cycles mid-burst.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      feed(2, 8'hC0 + 8'(k));
      expect_wr(2, 8'hC0 + 8'(k));
    end
    wait_wr(16'd2);
    bus.full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_stall", {24'h0, bus.write_enb, bus.req_ready, bus.grant_vld, bus.grant_id},
            {24'h0, 1'b0, 4'b0000, 1'b1, 2'd2});
    end
    step();
    bus.full = 1'b0;
    wait_wr(16'd4);
    @(negedge clk);
    check("t3_burst_end_bubble", {30'h0, bus.write_enb, bus.grant_vld}, 32'd0);
    drain();
    wait_wr(16'd5);

    // T4: requester 1 drops valid after 2 writes; next goes to 3, then 0.
    do_reset();
    feed(1, 8'h40);
    feed(1, 8'h41);
    expect_wr(1, 8'h40);
    expect_wr(1, 8'h41);
    expect_wr(3, 8'h60);
    expect_wr(0, 8'h50);
    wait_wr(16'd1);
    feed(3, 8'h60);
    feed(0, 8'h50);
    @(negedge clk);
    @(negedge clk);
    check("t4_drop_release_cycle", {28'h0, bus.write_enb, bus.grant_vld, bus.grant_id},
          {28'h0, 1'b0, 1'b1, 2'd1});
    @(negedge clk);
    check("t4_bubble", {31'h0, bus.grant_vld}, 32'd0);
    @(negedge clk);
    check("t4_next_grant", {29'h0, bus.grant_vld, bus.grant_id}, {29'h0, 1'b1, 2'd3});
    drain();

    // T5: reset in the 3rd write cycle of a burst.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      feed(0, 8'h70 + 8'(k));
      expect_wr(0, 8'h70 + 8'(k));
    end
    wait_wr(16'd2);
    check("t5_pre_reset", {23'h0, bus.write_enb, bus.data_in}, {23'h0, 1'b1, 8'h72});
    reset = 1'b1;
    #1;
    chk_idle("t5_reset_async");
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    feed(3, 8'h90);
    feed(0, 8'h80);
    feed(0, 8'h81);
    expect_wr(0, 8'h80);
    expect_wr(0, 8'h81);
    expect_wr(3, 8'h90);
    drain();
    step();
    check("t5_wr_count_restart", {16'h0, bus.wr_count}, 32'd3);
  endtask

  // ---------------- saturation on dut2 ----------------
  task automatic run_sat();
    int writes;
    writes        = 0;
    reset2        = 1'b1;
    bus2.full     = 1'b0;
    bus2.req_valid = 2'b00;
    bus2.req_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    reset2         = 1'b0;
    bus2.req_valid = 2'b01;
    bus2.req_data  = 16'h005A;
    for (int c = 0; c < 80000 && writes < 70000; c++) begin
      @(negedge clk);
      if (writes == 1000 || writes == 65534 || writes == 65535 || writes == 69999)
        check("sat_count", {16'h0, bus2.wr_count}, (writes > 65535) ? 32'd65535 : writes);
      if (bus2.write_enb === 1'b1) writes++;
    end
    check("sat_writes_done", writes, 70000);
    @(posedge clk);
    #2;
    check("sat_final", {16'h0, bus2.wr_count}, 32'h0000_FFFF);
  endtask

  initial begin
    reset    = 1'b1;
    reset2   = 1'b1;
    bus.full = 1'b0;
    fork
      run_main();
      run_sat();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
